// File: rtl/serial_paralelo_align_pkg.sv
// Shared constants for the comma-aligning serial-to-parallel converter:
// K28.5 patterns for both running disparities and the alignment FSM encoding.
package serial_paralelo_align_pkg;

   localparam logic [9:0] K28_5_RDN = 10'b0011111010;
   localparam logic [9:0] K28_5_RDP = 10'b1100000101;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      SYNCING = 2'd1,
      LOCKED  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_paralelo_align_comma_detect.sv
// Combinational comma detector: flags a window equal to either disparity
// variant of the alignment pattern.
module comma_detect
   import serial_paralelo_align_pkg::*;
#(
   parameter int              WIDTH   = 10,
   parameter logic [WIDTH-1:0] COMMA_P = WIDTH'(K28_5_RDN),
   parameter logic [WIDTH-1:0] COMMA_N = WIDTH'(K28_5_RDP)
) (
   input  logic [WIDTH-1:0] sr_next,
   output logic             match
);

   assign match = (sr_next == COMMA_P) || (sr_next == COMMA_N);

endmodule

// File: rtl/serial_paralelo_align.sv
// Serial-to-parallel converter with comma alignment (SEARCH/SYNCING/LOCKED).
// Define ALIGN_ERRCNT_EN to add err_cnt, counting misaligned commas seen while locked.
// Handshake: word_valid is a one-cycle pulse, no ready; word_out is only
// meaningful on that pulse and otherwise holds its last value.
module serial_paralelo_align
   import serial_paralelo_align_pkg::*;
#(
   parameter int               WIDTH     = 10,
   parameter logic [WIDTH-1:0] COMMA_P   = WIDTH'(K28_5_RDN),
   parameter logic [WIDTH-1:0] COMMA_N   = WIDTH'(K28_5_RDP),
   parameter int               COMMA_REQ = 4
) (
   input  logic             CLOCK,
   input  logic             reset_L,
   input  logic             serial_in,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   output logic             locked,
   output logic             comma_seen,
`ifdef ALIGN_ERRCNT_EN
   output logic [7:0]       err_cnt,
`endif
   output logic [1:0]       state_dbg,
   output logic [3:0]       cnt_dbg
);

   localparam logic [3:0] LAST_PHASE = 4'(WIDTH - 1);
   localparam logic [3:0] REQ        = 4'(COMMA_REQ);

   state_t           state, state_n;
   logic [WIDTH-1:0] sr, sr_next;
   logic [3:0]       phase, phase_n;
   logic [3:0]       cnt, cnt_n;
   logic             match, boundary, load_word, err_inc;

   assign sr_next  = {sr[WIDTH-2:0], serial_in};
   assign boundary = (phase == LAST_PHASE);

   comma_detect #(
      .WIDTH   (WIDTH),
      .COMMA_P (COMMA_P),
      .COMMA_N (COMMA_N)
   ) u_comma_detect (
      .sr_next (sr_next),
      .match   (match)
   );

   always_comb begin
      state_n   = state;
      phase_n   = boundary ? 4'd0 : phase + 4'd1;
      cnt_n     = cnt;
      load_word = 1'b0;
      err_inc   = 1'b0;
      case (state)
         SEARCH: begin
            if (match) begin
               phase_n = 4'd0;
               if (REQ == 4'd1) begin
                  state_n = LOCKED;
                  cnt_n   = REQ;
               end else begin
                  state_n = SYNCING;
                  cnt_n   = 4'd1;
               end
            end
         end
         SYNCING: begin
            if (boundary) begin
               if (match) begin
                  // Saturate at REQ so a realign from LOCKED with REQ==1 still relocks.
                  if (cnt >= REQ - 4'd1) begin
                     state_n = LOCKED;
                     cnt_n   = REQ;
                  end else begin
                     cnt_n = cnt + 4'd1;
                  end
               end else begin
                  state_n = SEARCH;
                  cnt_n   = 4'd0;
               end
            end else if (match) begin
               phase_n = 4'd0;
               cnt_n   = 4'd1;
            end
         end
         LOCKED: begin
            if (boundary) begin
               load_word = 1'b1;
            end else if (match) begin
               state_n = SYNCING;
               phase_n = 4'd0;
               cnt_n   = 4'd1;
               err_inc = 1'b1;
            end
         end
         default: state_n = SEARCH;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (!reset_L) begin
         state      <= SEARCH;
         sr         <= '0;
         phase      <= 4'd0;
         cnt        <= 4'd0;
         word_out   <= '0;
         word_valid <= 1'b0;
         locked     <= 1'b0;
         comma_seen <= 1'b0;
      end else begin
         state      <= state_n;
         sr         <= sr_next;
         phase      <= phase_n;
         cnt        <= cnt_n;
         word_valid <= load_word;
         locked     <= (state_n == LOCKED);
         comma_seen <= match;
         if (load_word) word_out <= sr_next;
      end
   end

`ifdef ALIGN_ERRCNT_EN
   always_ff @(posedge CLOCK) begin
      if (!reset_L)                     err_cnt <= 8'd0;
      else if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
   end
`else
   logic unused_err;
   assign unused_err = err_inc;
`endif

   assign state_dbg = state;
   assign cnt_dbg   = cnt;

endmodule

// File: tb/tb_serial_paralelo_align.sv
// Directed bench for serial_paralelo_align: lock, data, realign, loss of sync,
// alternating disparity and mid-symbol reset.
module tb_serial_paralelo_align;
   import serial_paralelo_align_pkg::*;

   logic       CLOCK = 1'b0;
   logic       reset_L = 1'b0;
   logic       serial_in = 1'b0;
   logic [9:0] word_out;
   logic       word_valid, locked, comma_seen;
   logic [1:0] state_dbg;
   logic [3:0] cnt_dbg;
`ifdef ALIGN_ERRCNT_EN
   logic [7:0] err_cnt;
`endif

   int pass_cnt  = 0;
   int check_cnt = 0;
   logic [9:0] exp_q[$];

   serial_paralelo_align dut (
      .CLOCK      (CLOCK),
      .reset_L    (reset_L),
      .serial_in  (serial_in),
      .word_out   (word_out),
      .word_valid (word_valid),
      .locked     (locked),
      .comma_seen (comma_seen),
`ifdef ALIGN_ERRCNT_EN
      .err_cnt    (err_cnt),
`endif
      .state_dbg  (state_dbg),
      .cnt_dbg    (cnt_dbg)
   );

   always #5 CLOCK = ~CLOCK;

   // Scoreboard: every word_valid pulse must match the next expected word.
   always @(negedge CLOCK) begin
      if (word_valid) begin
         check_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL word_valid_unexpected: got word %h, expected no valid pulse", word_out);
         end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            if (word_out !== e) $display("FAIL scoreboard_word: got %h, expected %h", word_out, e);
            else pass_cnt++;
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      check_cnt++;
      if (got !== exp) $display("FAIL %s: got %h, expected %h", name, got, exp);
      else pass_cnt++;
   endtask

   task automatic send_bit(input logic b);
      serial_in = b;
      @(posedge CLOCK);
      #1;
   endtask

   task automatic send_sym(input logic [9:0] s);
      for (int i = 9; i >= 0; i--) send_bit(s[i]);
   endtask

   task automatic do_reset();
      reset_L   = 1'b0;
      serial_in = 1'b0;
      @(posedge CLOCK);
      #1;
      reset_L = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      chk("reset_word_out", 16'(word_out), 16'h000);
      chk("reset_word_valid", 16'(word_valid), 16'h0);
      chk("reset_locked", 16'(locked), 16'h0);
      chk("reset_comma_seen", 16'(comma_seen), 16'h0);
      chk("reset_state", 16'(state_dbg), 16'(SEARCH));
      chk("reset_cnt", 16'(cnt_dbg), 16'h0);
`ifdef ALIGN_ERRCNT_EN
      chk("reset_err_cnt", 16'(err_cnt), 16'h0);
`endif
   endtask

   task automatic test_lock();
      send_sym(K28_5_RDN);
      chk("lock_c1_state", 16'(state_dbg), 16'(SYNCING));
      chk("lock_c1_cnt", 16'(cnt_dbg), 16'h1);
      chk("lock_c1_comma_seen", 16'(comma_seen), 16'h1);
      send_sym(K28_5_RDN);
      send_sym(K28_5_RDN);
      chk("lock_c3_locked", 16'(locked), 16'h0);
      chk("lock_c3_cnt", 16'(cnt_dbg), 16'h3);
      send_sym(K28_5_RDN);
      chk("lock_c4_locked", 16'(locked), 16'h1);
      chk("lock_c4_state", 16'(state_dbg), 16'(LOCKED));
      chk("lock_c4_word_valid", 16'(word_valid), 16'h0);
   endtask

   task automatic test_data();
      exp_q.push_back(10'h2AA);
      send_sym(10'h2AA);
      chk("data_word_valid", 16'(word_valid), 16'h1);
      chk("data_word_out", 16'(word_out), 16'h2AA);
   endtask

   task automatic test_realign();
      send_bit(1'b0);
      chk("realign_valid_drop", 16'(word_valid), 16'h0);
      chk("realign_word_hold", 16'(word_out), 16'h2AA);
      // The old boundary falls one bit before the shifted comma ends.
      exp_q.push_back(10'b0001111101);
      send_sym(K28_5_RDN);
      chk("realign_locked", 16'(locked), 16'h0);
      chk("realign_state", 16'(state_dbg), 16'(SYNCING));
      chk("realign_cnt", 16'(cnt_dbg), 16'h1);
      chk("realign_no_valid", 16'(word_valid), 16'h0);
`ifdef ALIGN_ERRCNT_EN
      chk("realign_err_cnt", 16'(err_cnt), 16'h1);
`endif
      send_sym(K28_5_RDN);
      send_sym(K28_5_RDN);
      chk("realign_c3_locked", 16'(locked), 16'h0);
      send_sym(K28_5_RDN);
      chk("realign_relock", 16'(locked), 16'h1);
      exp_q.push_back(K28_5_RDN);
      send_sym(K28_5_RDN);
      chk("realign_comma_word", 16'(word_out), 16'(K28_5_RDN));
      chk("realign_comma_valid", 16'(word_valid), 16'h1);
   endtask

   task automatic test_lose_sync();
      do_reset();
      send_sym(K28_5_RDN);
      send_sym(K28_5_RDN);
      chk("lose_syncing_cnt", 16'(cnt_dbg), 16'h2);
      send_sym(10'h155);
      chk("lose_state", 16'(state_dbg), 16'(SEARCH));
      chk("lose_cnt", 16'(cnt_dbg), 16'h0);
      chk("lose_locked", 16'(locked), 16'h0);
   endtask

   task automatic test_alternating();
      do_reset();
      send_sym(K28_5_RDN);
      send_sym(K28_5_RDP);
      send_sym(K28_5_RDN);
      chk("alt_c3_locked", 16'(locked), 16'h0);
      send_sym(K28_5_RDP);
      chk("alt_c4_locked", 16'(locked), 16'h1);
      exp_q.push_back(10'h155);
      send_sym(10'h155);
      chk("alt_data_word", 16'(word_out), 16'h155);
   endtask

   task automatic test_reset_mid();
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      do_reset();
      chk("mid_word_out", 16'(word_out), 16'h000);
      chk("mid_word_valid", 16'(word_valid), 16'h0);
      chk("mid_locked", 16'(locked), 16'h0);
      chk("mid_comma_seen", 16'(comma_seen), 16'h0);
      chk("mid_state", 16'(state_dbg), 16'(SEARCH));
`ifdef ALIGN_ERRCNT_EN
      chk("mid_err_cnt", 16'(err_cnt), 16'h0);
`endif
      send_sym(K28_5_RDP);
      send_sym(K28_5_RDP);
      send_sym(K28_5_RDP);
      chk("mid_c3_locked", 16'(locked), 16'h0);
      send_sym(K28_5_RDP);
      chk("mid_relock", 16'(locked), 16'h1);
      exp_q.push_back(10'h2AA);
      send_sym(10'h2AA);
      send_bit(1'b0);
   endtask

   initial begin
      test_reset();
      test_lock();
      test_data();
      test_realign();
      test_lose_sync();
      test_alternating();
      test_reset_mid();
      repeat (3) @(posedge CLOCK);
      chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
